// File: rtl/ll_pkg.sv
// Shared definitions for the line-length window-sum block: FSM encoding and
// accumulator sizing.
package ll_pkg;

    typedef logic [0:0] ll_state_t;

    localparam ll_state_t ST_FILL = 1'b0;
    localparam ll_state_t ST_RUN  = 1'b1;

    localparam int HIT_W = 8;

    // A win_len-sample sum of data_width-bit values needs log2(win_len) extra bits.
    function automatic int acc_width_f(input int data_w, input int win_l);
        return data_w + $clog2(win_l);
    endfunction

    function automatic int ptr_width_f(input int win_l);
        return (win_l > 1) ? $clog2(win_l) : 1;
    endfunction

endpackage

// File: rtl/ll_ring_buf.sv
// Sample ring storage: one write port and an asynchronous read of the same
// address, so the slot being overwritten is visible before the write lands.
module ll_ring_buf #(
    parameter int width = 32,
    parameter int depth = 16,
    parameter int addr_w = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [addr_w-1:0] addr_i,
    input  logic [width-1:0]  wdata_i,
    output logic [width-1:0]  rdata_o
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ll_window_sum.sv
// Sliding-window sum of rectified line-length samples with a persistence-
// filtered over-threshold alarm.
//
// Handshake: a sample is taken on every rising edge with en=0 (no backpressure);
// dout_valid is a one-cycle pulse one edge after the sample that yields a full
// window, and dout holds between pulses.
module ll_window_sum
    import ll_pkg::*;
#(
    parameter int data_width = 32,
    parameter int win_len    = 16,
    parameter int persist    = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              en,
    input  logic signed [data_width-1:0]                      din,
    input  logic [acc_width_f(data_width, win_len)-1:0]       thresh,
    output logic [acc_width_f(data_width, win_len)-1:0]       dout,
    output logic                                              dout_valid,
    output logic                                              alarm,
    output logic                                              dbg_state
);

    localparam int ACC_W = acc_width_f(data_width, win_len);
    localparam int PTR_W = ptr_width_f(win_len);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(win_len - 1);
    localparam logic [HIT_W-1:0] PERSIST_CNT = HIT_W'(persist);

    ll_state_t        state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             alarm_q, alarm_d;

    logic                  accept;
    logic [data_width-1:0] din_c;
    logic [data_width-1:0] ring_rdata;
    logic [ACC_W-1:0]      old_val;
    logic                  win_valid;

    assign accept = !en;
    // Negative line length is meaningless upstream noise; treat it as zero.
    assign din_c  = din[data_width-1] ? '0 : din;

    ll_ring_buf #(
        .width (data_width),
        .depth (win_len),
        .addr_w(PTR_W)
    ) u_ring (
        .clk_i  (clk),
        .we_i   (accept && !rst),
        .addr_i (wr_ptr_q),
        .wdata_i(din_c),
        .rdata_o(ring_rdata)
    );

    // Ring contents are never reset, so the oldest slot only counts once the
    // window has been filled with fresh samples.
    assign old_val   = (state_q == ST_RUN) ? ACC_W'(ring_rdata) : '0;
    assign win_valid = accept && ((state_q == ST_RUN) || (fill_cnt_q == FILL_LAST));

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        alarm_d      = alarm_q;

        if (accept) begin
            sum_d    = sum_q + ACC_W'(din_c) - old_val;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (state_q == ST_FILL) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_RUN;
                end
            end
        end

        if (win_valid) begin
            dout_d       = sum_d;
            dout_valid_d = 1'b1;
            if (sum_d > thresh) begin
                hit_cnt_d = (hit_cnt_q >= PERSIST_CNT) ? PERSIST_CNT : hit_cnt_q + 1'b1;
                alarm_d   = (hit_cnt_d == PERSIST_CNT);
            end else begin
                hit_cnt_d = '0;
                alarm_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            hit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            alarm_q      <= alarm_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign alarm      = alarm_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ll_window_sum.sv
// Directed bench for ll_window_sum (win_len=4, persist=2): stimulus pushes the
// hand-computed {alarm, dout} for each full window; a monitor pops on dout_valid.
module tb_ll_window_sum;

    localparam int DW    = 32;
    localparam int WL    = 4;
    localparam int PER   = 2;
    localparam int ACC_W = DW + 2;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] din;
    logic [ACC_W-1:0]     thresh;
    logic [ACC_W-1:0]     dout;
    logic                 dout_valid;
    logic                 alarm;
    logic                 dbg_state;

    logic [ACC_W:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    ll_window_sum #(
        .data_width(DW),
        .win_len   (WL),
        .persist   (PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .thresh    (thresh),
        .dout      (dout),
        .dout_valid(dout_valid),
        .alarm     (alarm),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout", longint'(dout), 0);
        check("rst_valid", longint'(dout_valid), 0);
        check("rst_alarm", longint'(alarm), 0);
        check("rst_state", longint'(dbg_state), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // driver: one accepted sample; push expectation when it completes a window
    task automatic send(input int v, input bit has_exp, input longint exp_dout, input bit exp_alarm);
        en  = 1'b0;
        din = v;
        if (has_exp) exp_q.push_back({exp_alarm, ACC_W'(exp_dout)});
        @(posedge clk);
        #1 en = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [ACC_W:0] e;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: dout=%0d with no window expected (time %0t)", dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("win_dout", longint'(dout), longint'(e[ACC_W-1:0]));
                    check("win_alarm", longint'(alarm), longint'(e[ACC_W]));
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        din    = '0;
        thresh = ACC_W'(10);

        do_reset();

        // fill: first pulse only after the 4th sample; 20 > 10 -> hit 1, no alarm
        send(5, 0, 0, 0);
        send(5, 0, 0, 0);
        send(5, 0, 0, 0);
        send(5, 1, 20, 0);

        // slide in 1s across the ring wrap, with a 3-cycle idle gap
        send(1, 1, 16, 1);
        send(1, 1, 12, 1);
        repeat (3) begin
            @(negedge clk);
            check("hold_dout", longint'(dout), 12);
            check("hold_alarm", longint'(alarm), 1);
            @(posedge clk);
            #1;
        end
        send(1, 1, 8, 0);
        send(1, 1, 4, 0);

        // new threshold applies to the next window; equal-to-threshold is not a hit
        thresh = ACC_W'(6);
        send(2, 1, 5, 0);
        send(2, 1, 6, 0);
        send(2, 1, 7, 0);
        send(2, 1, 8, 1);
        send(-3, 1, 6, 0);

        // reset after a partial window: stale data and hit count are discarded
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        send(9, 0, 0, 0);
        send(9, 0, 0, 0);
        do_reset();
        send(7, 0, 0, 0);
        send(7, 0, 0, 0);
        send(7, 0, 0, 0);
        send(7, 1, 28, 0);

        repeat (4) @(negedge clk);
        check("drain", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ll_window_sum.md
LL_WINDOW_SUM -- requirements
Module: ll_window_sum

Interface
REQ-001 SHALL have parameter data_width, default 32: sample width, matching the upstream line-length stage output.
REQ-002 SHALL have parameter win_len, default 16: window length in samples; power of two, 2..256.
REQ-003 SHALL have parameter persist, default 4: consecutive over-threshold windows required to raise alarm; range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: sample strobe, active-low; din is accepted on any rising edge where en=0.
REQ-007 SHALL have port din, input, data_width bits, signed: per-sample line length from the upstream stage.
REQ-008 SHALL have port thresh, input, acc_width bits, unsigned: alarm threshold, sampled on every cycle.
REQ-009 SHALL have port dout, output reg, acc_width bits, unsigned: windowed sum; acc_width = data_width + log2(win_len).
REQ-010 SHALL have port dout_valid, output reg, 1 bit: one-cycle pulse, dout updated and window full.
REQ-011 SHALL have port alarm, output reg, 1 bit: level, persistent over-threshold detection.

Function
REQ-012 SHALL treat a negative din (MSB=1) as 0 before any use; no other input conditioning.
REQ-013 SHALL, on an accepted sample, write the conditioned din into ring slot wr_ptr and advance wr_ptr modulo win_len.
REQ-014 SHALL, on the same edge, update sum <= sum + din_c - old, where old = ring[wr_ptr] in RUN and 0 in FILL.
REQ-015 SHALL size sum at acc_width bits, so overflow is impossible; no saturation logic.
REQ-016 SHALL implement states FILL and RUN: FILL → RUN on the accepted sample that makes fill_cnt reach win_len; RUN has no exit except rst.
REQ-017 SHALL drive dout = new sum and dout_valid = 1 on the edge that accepts a sample and either completes FILL or occurs in RUN (latency 1 clk from sample to dout).
REQ-018 SHALL drive dout_valid = 0 on every other edge; dout holds its last value.
REQ-019 SHALL, when en=1, hold all state (sum, pointers, counters, alarm, dout).
REQ-020 SHALL compare only on valid windows: dout_next > thresh increments hit_cnt, saturating at persist; dout_next <= thresh clears hit_cnt to 0.
REQ-021 SHALL assert alarm on the edge at which hit_cnt reaches persist, and deassert it on the edge at which a valid window ≤ thresh is produced, coincident with that dout_valid.
REQ-022 SHALL apply a thresh change to the next valid window only; it never retro-evaluates.
REQ-023 SHALL, when wr_ptr wraps from win_len-1 to 0, behave identically to any other slot.

Reset
REQ-024 SHALL, while rst=1, force state=FILL, sum=0, wr_ptr=0, fill_cnt=0, hit_cnt=0, dout=0, dout_valid=0, alarm=0; rst has priority over en.
REQ-025 SHALL NOT require the ring contents to be reset (FILL gating per REQ-014 makes stale data irrelevant).
REQ-026 SHALL, on rst mid-operation, discard the partial window; the next dout_valid follows exactly win_len new accepted samples.

Structure
REQ-027 SHALL place the FILL/RUN state encoding and the acc_width derivation function in shared package ll_pkg.
REQ-028 SHALL implement the ring as sub-module ll_ring_buf (write port plus same-address read-before-write, no reset); control, sum and alarm logic stay in ll_window_sum.

Verification (win_len=4, persist=2, data_width=32)
REQ-029 SHALL verify: rst, then din=5 ×4 with en=0 → dout_valid first pulses 1 clk after the 4th sample with dout=20, and no pulse before it.
REQ-030 SHALL verify: continue with din=1 ×4 → dout=16,12,8,4 with one dout_valid per sample.
REQ-031 SHALL verify: en=1 for 3 cycles between samples → no dout_valid, dout/alarm unchanged; the next sample resumes the sequence correctly.
REQ-032 SHALL verify: thresh=10, windows 20,16,8 → alarm=0 after 20, 1 after 16, 0 after 8.
REQ-033 SHALL verify: din=-3 inside a full window of 2s → dout=6 (the -3 is counted as 0).
REQ-034 SHALL verify: rst after 2 of 4 fill samples, then 4 samples of 7 → single dout_valid after the 4th, dout=28.
